// File: rtl/fu_seq.sv
`timescale 1ns/1ps
// fu_seq: registered 16-function unit, 1-cycle latency (FMUL: W+1 cycles, iterative shift-add).
// Result held in RESULT until out_ready; in_ready is high only in IDLE, so no new op while a result waits.
package mycpu_pkg;
  typedef enum logic [3:0] {
    FMOVA = 4'd0,  FINC = 4'd1,  FADD  = 4'd2,  FSUB = 4'd3,
    FDEC  = 4'd4,  FSRA = 4'd5,  FSLA  = 4'd6,  FAND = 4'd7,
    FOR   = 4'd8,  FXOR = 4'd9,  FNOT  = 4'd10, FMOVB = 4'd11,
    FSHR  = 4'd12, FSHL = 4'd13, FMUL  = 4'd14, FUSR = 4'd15
  } fs_t;
endpackage

module fu_seq
  import mycpu_pkg::*;
#(
  parameter int W     = 16,
  parameter int PI_Q8 = 804
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  fs_t          fs_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] f_out,
  output logic [1:0]   nz_out,
  output logic         v_out
);

  localparam int CW = $clog2(W);
  localparam logic [2*W-1:0] POS_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [2*W-1:0] NEG_MAG = POS_MAX + 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_RESULT} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic           sign_q, sign_d;
  logic [W-1:0]   f_q, f_d;
  logic           v_q, v_d;

  logic [W-1:0]   alu_f;
  logic           alu_v;
  logic [3:0]     sh_k;
  logic [W-1:0]   usr_d;
  logic [W+31:0]  usr_p, usr_r;
  logic [W-1:0]   a_mag, b_mag;
  logic [2*W-1:0] acc_nxt;

  always_comb begin
    alu_f = '0;
    alu_v = 1'b0;
    sh_k  = {1'b0, b_in[2:0]} + 4'd1;
    usr_d = {a_in[W-2:0], 1'b0};
    usr_p = (W+32)'(usr_d) * (W+32)'(PI_Q8);
    usr_r = usr_p >> 8;
    case (fs_in)
      FMOVA: alu_f = a_in;
      FINC:  alu_f = a_in + W'(1);
      FADD:  alu_f = a_in + b_in;
      FSUB:  alu_f = a_in - b_in;
      FDEC:  alu_f = a_in - W'(1);
      FSRA:  alu_f = $signed(a_in) >>> sh_k;
      FSLA:  alu_f = a_in << sh_k;
      FAND:  alu_f = a_in & b_in;
      FOR:   alu_f = a_in | b_in;
      FXOR:  alu_f = a_in ^ b_in;
      FNOT:  alu_f = ~a_in;
      FMOVB: alu_f = b_in;
      FSHR:  alu_f = b_in >> 1;
      FSHL:  alu_f = b_in << 1;
      FUSR: begin
        if (|usr_r[W+31:W]) begin
          alu_f = '1;
          alu_v = 1'b1;
        end else begin
          alu_f = usr_r[W-1:0];
        end
      end
      default: alu_f = '0;
    endcase
  end

  // Magnitudes as unsigned W bits: -2^(W-1) maps to 2^(W-1) without loss.
  assign a_mag   = a_in[W-1] ? (W'(0) - a_in) : a_in;
  assign b_mag   = b_in[W-1] ? (W'(0) - b_in) : b_in;
  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    sign_d   = sign_q;
    f_d      = f_q;
    v_d      = v_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (fs_in == FMUL) begin
            mcand_d  = {{W{1'b0}}, a_mag};
            mplier_d = b_mag;
            acc_d    = '0;
            sign_d   = a_in[W-1] ^ b_in[W-1];
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            f_d     = alu_f;
            v_d     = alu_v;
            state_d = S_RESULT;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(W-1)) begin
          cnt_d   = '0;
          state_d = S_RESULT;
          // Negative side may reach exactly 2^(W-1) before clamping.
          if (sign_q) begin
            if (acc_nxt > NEG_MAG) begin
              f_d = {1'b1, {(W-1){1'b0}}};
              v_d = 1'b1;
            end else begin
              f_d = W'(0) - acc_nxt[W-1:0];
              v_d = 1'b0;
            end
          end else begin
            if (acc_nxt > POS_MAX) begin
              f_d = {1'b0, {(W-1){1'b1}}};
              v_d = 1'b1;
            end else begin
              f_d = acc_nxt[W-1:0];
              v_d = 1'b0;
            end
          end
        end
      end
      S_RESULT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      f_q      <= '0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      sign_q   <= sign_d;
      f_q      <= f_d;
      v_q      <= v_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_RESULT);
  assign f_out     = f_q;
  assign v_out     = v_q;
  assign nz_out    = {f_q[W-1], (f_q == '0)};

endmodule
